// File: rtl/axi_mem_slave_pkg.sv
// Shared encodings and FSM state types for the AXI memory slave.
// Burst/response codes follow the AXI4 channel definitions.
package axi_mem_slave_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [2:0] SIZE_WORD   = 3'b010;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } w_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } r_state_t;

   // Only full-word FIXED/INCR bursts touch memory.
   function automatic logic burst_err(input logic [2:0] size,
                                      input logic [1:0] burst);
      return (size != SIZE_WORD) ||
             (burst == BURST_WRAP) ||
             (burst == BURST_RSVD);
   endfunction

   function automatic logic burst_incr(input logic [1:0] burst);
      return burst == BURST_INCR;
   endfunction

   function automatic logic burst_fixed(input logic [1:0] burst);
      return burst == BURST_FIXED;
   endfunction

endpackage

// File: rtl/axi_mem_sdp_ram.sv
// Simple dual-port 32-bit RAM: byte-enabled write port, registered
// read port that returns the pre-write contents on an address collision.
module axi_mem_sdp_ram #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) begin
            mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave over a word-addressed SRAM with independent
// read and write engines, each moving one beat per cycle.
module axi_mem_slave #(
   parameter int MEM_AW    = 12,
   parameter bit INIT_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        areset,
   input  logic        s_axi_awid,
   input  logic [31:0] s_axi_awaddr,
   input  logic [7:0]  s_axi_awlen,
   input  logic [2:0]  s_axi_awsize,
   input  logic [1:0]  s_axi_awburst,
   input  logic        s_axi_awlock,
   input  logic [3:0]  s_axi_awcache,
   input  logic [2:0]  s_axi_awprot,
   input  logic [3:0]  s_axi_awqos,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wlast,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic        s_axi_bid,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic        s_axi_arid,
   input  logic [31:0] s_axi_araddr,
   input  logic [7:0]  s_axi_arlen,
   input  logic [2:0]  s_axi_arsize,
   input  logic [1:0]  s_axi_arburst,
   input  logic [1:0]  s_axi_arlock,
   input  logic [3:0]  s_axi_arcache,
   input  logic [2:0]  s_axi_arprot,
   input  logic [3:0]  s_axi_arqos,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic        s_axi_rid,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rlast,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic [15:0] wr_bursts,
   output logic [15:0] rd_bursts
);

   import axi_mem_slave_pkg::*;

   w_state_t          w_state;
   logic [MEM_AW-1:0] w_idx;
   logic [7:0]        w_cnt;
   logic              w_incr;
   logic              w_err;
   logic              w_slv;
   logic              w_final;
   logic              w_lerr;

   r_state_t          r_state;
   logic [MEM_AW-1:0] r_idx;
   logic [MEM_AW-1:0] ar_idx;
   logic [MEM_AW-1:0] aw_idx;
   logic [7:0]        r_cnt;
   logic              r_incr;
   logic              r_err;
   logic              ar_err;

   logic [3:0]        ram_we;
   logic              ram_re;
   logic [MEM_AW-1:0] ram_raddr;
   logic [31:0]       ram_q;

   assign aw_idx  = s_axi_awaddr[MEM_AW+1:2];
   assign ar_idx  = s_axi_araddr[MEM_AW+1:2];
   assign ar_err  = burst_err(s_axi_arsize, s_axi_arburst);
   assign w_final = (w_cnt == 8'd0);
   assign w_lerr  = (s_axi_wlast != w_final);

   // Erroneous bursts still consume beats but never reach the array.
   assign ram_we = (s_axi_wready && s_axi_wvalid && !w_err) ?
                   s_axi_wstrb : 4'h0;

   assign s_axi_rdata = r_err ? 32'h0 : ram_q;

   // Beat 0 is fetched on the AR handshake, later beats on the
   // handshake of the previous one; a stall simply holds ram_q.
   always_comb begin
      ram_re    = 1'b0;
      ram_raddr = ar_idx;
      if (r_state == R_IDLE) begin
         ram_re = s_axi_arvalid && s_axi_arready;
      end else begin
         ram_re    = s_axi_rready && !s_axi_rlast;
         ram_raddr = r_idx;
      end
   end

   axi_mem_sdp_ram #(
      .AW (MEM_AW)
   ) u_ram (
      .clk   (clk),
      .rst   (areset),
      .we    (ram_we),
      .waddr (w_idx),
      .wdata (s_axi_wdata),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_q)
   );

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         w_state       <= W_IDLE;
         s_axi_awready <= 1'b1;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= RESP_OKAY;
         s_axi_bid     <= 1'b0;
         w_idx         <= '0;
         w_cnt         <= '0;
         w_incr        <= 1'b0;
         w_err         <= 1'b0;
         w_slv         <= 1'b0;
         wr_bursts     <= '0;
      end else begin
         unique case (w_state)
            W_IDLE: begin
               if (s_axi_awvalid) begin
                  s_axi_awready <= 1'b0;
                  s_axi_wready  <= 1'b1;
                  s_axi_bid     <= s_axi_awid;
                  w_idx         <= aw_idx;
                  w_cnt         <= s_axi_awlen;
                  w_incr        <= burst_incr(s_axi_awburst);
                  w_err         <= burst_err(s_axi_awsize, s_axi_awburst);
                  w_slv         <= burst_err(s_axi_awsize, s_axi_awburst);
                  w_state       <= W_DATA;
               end
            end
            W_DATA: begin
               if (s_axi_wvalid) begin
                  w_cnt <= w_cnt - 8'd1;
                  if (w_lerr) begin
                     w_slv <= 1'b1;
                  end
                  if (w_incr) begin
                     w_idx <= w_idx + 1'b1;
                  end
                  if (w_final) begin
                     s_axi_wready <= 1'b0;
                     s_axi_bvalid <= 1'b1;
                     s_axi_bresp  <= (w_slv || w_lerr) ?
                                     RESP_SLVERR : RESP_OKAY;
                     w_state      <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid  <= 1'b0;
                  s_axi_awready <= 1'b1;
                  wr_bursts     <= wr_bursts + 16'd1;
                  w_state       <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_state       <= R_IDLE;
         s_axi_arready <= 1'b1;
         s_axi_rvalid  <= 1'b0;
         s_axi_rlast   <= 1'b0;
         s_axi_rid     <= 1'b0;
         s_axi_rresp   <= RESP_OKAY;
         r_idx         <= '0;
         r_cnt         <= '0;
         r_incr        <= 1'b0;
         r_err         <= 1'b0;
         rd_bursts     <= '0;
      end else begin
         unique case (r_state)
            R_IDLE: begin
               if (s_axi_arvalid) begin
                  s_axi_arready <= 1'b0;
                  s_axi_rvalid  <= 1'b1;
                  s_axi_rlast   <= (s_axi_arlen == 8'd0);
                  s_axi_rid     <= s_axi_arid;
                  s_axi_rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
                  r_err         <= ar_err;
                  r_incr        <= burst_incr(s_axi_arburst);
                  r_cnt         <= s_axi_arlen;
                  r_idx         <= burst_fixed(s_axi_arburst) ?
                                   ar_idx : ar_idx + 1'b1;
                  r_state       <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axi_rready) begin
                  if (s_axi_rlast) begin
                     s_axi_rvalid  <= 1'b0;
                     s_axi_rlast   <= 1'b0;
                     s_axi_arready <= 1'b1;
                     rd_bursts     <= rd_bursts + 16'd1;
                     r_state       <= R_IDLE;
                  end else begin
                     r_cnt       <= r_cnt - 8'd1;
                     s_axi_rlast <= (r_cnt == 8'd1);
                     if (r_incr) begin
                        r_idx <= r_idx + 1'b1;
                     end
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                        s_axi_awqos, s_axi_arlock, s_axi_arcache,
                        s_axi_arprot, s_axi_arqos,
                        s_axi_awaddr[1:0], s_axi_awaddr[31:MEM_AW+2],
                        s_axi_araddr[1:0], s_axi_araddr[31:MEM_AW+2],
                        INIT_ZERO};

endmodule

// File: tb/tb_axi_mem_slave.sv
// Bench for axi_mem_slave: directed scenarios plus randomized bursts,
// all outputs compared every cycle against a transaction-level model.
module tb_axi_mem_slave;

   localparam int AW    = 12;
   localparam int DEPTH = 1 << AW;
   localparam int LIM   = 3000;

   logic        clk;
   logic        areset;
   logic        awid, awvalid, awready, awlock;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize, awprot;
   logic [1:0]  awburst;
   logic [3:0]  awcache, awqos;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic        bid, bvalid, bready;
   logic [1:0]  bresp;
   logic        arid, arvalid, arready;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize, arprot;
   logic [1:0]  arburst, arlock;
   logic [3:0]  arcache, arqos;
   logic        rid, rlast, rvalid, rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic [15:0] wr_bursts, rd_bursts;

   axi_mem_slave #(.MEM_AW(AW), .INIT_ZERO(1'b1)) dut (
      .clk(clk), .areset(areset),
      .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
      .s_axi_awsize(awsize), .s_axi_awburst(awburst),
      .s_axi_awlock(awlock), .s_axi_awcache(awcache),
      .s_axi_awprot(awprot), .s_axi_awqos(awqos),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
      .s_axi_bready(bready),
      .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
      .s_axi_arsize(arsize), .s_axi_arburst(arburst),
      .s_axi_arlock(arlock), .s_axi_arcache(arcache),
      .s_axi_arprot(arprot), .s_axi_arqos(arqos),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
      .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .wr_bursts(wr_bursts), .rd_bursts(rd_bursts)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
   endtask

   task automatic timeout(input string nm);
      n_tot++;
      $display("FAIL %s: timed out at %0t", nm, $time);
   endtask

   // ---------------- transaction-level model ----------------
   typedef struct {
      logic [31:0] d;
      bit          k;
      logic [1:0]  resp;
      bit          last;
      logic        id;
   } beat_t;

   logic [31:0] mm [DEPTH];
   bit          kn [DEPTH];
   beat_t       rq [$];
   logic [31:0] last_rd [$];
   int          last_rl;
   logic [1:0]  last_rresp;
   logic        last_rid;
   logic [1:0]  last_bresp;
   logic        last_bid;

   bit          w_act, w_rsp, w_incr, w_err, w_slv;
   logic        w_id;
   int          w_idx, w_left;
   logic [1:0]  e_bresp;
   bit          r_act;
   int          wr_cnt, rd_cnt;
   int          m_idx;
   bit          m_err;
   bit          p_stall;
   logic [31:0] p_d;
   logic        p_l, p_id;
   logic [1:0]  p_resp;
   beat_t       cur;

   function automatic bit is_err(input logic [2:0] sz,
                                 input logic [1:0] bu);
      return (sz != 3'd2) || (bu > 2'd1);
   endfunction

   always @(negedge clk) begin
      if (areset) begin
         w_act = 0; w_rsp = 0; r_act = 0; rq.delete();
         wr_cnt = 0; rd_cnt = 0; p_stall = 0;
      end else begin
         chk("wr_bursts", 32'(wr_bursts), wr_cnt & 32'hFFFF);
         chk("rd_bursts", 32'(rd_bursts), rd_cnt & 32'hFFFF);
         chk("awready", 32'(awready), 32'(!w_act));
         chk("wready", 32'(wready), 32'(w_act && !w_rsp));
         chk("bvalid", 32'(bvalid), 32'(w_rsp));
         chk("arready", 32'(arready), 32'(!r_act));
         chk("rvalid", 32'(rvalid), 32'(r_act));
         if (rvalid && rq.size() > 0) begin
            cur = rq[0];
            if (p_stall) begin
               chk("rdata_hold", rdata, p_d);
               chk("rlast_hold", 32'(rlast), 32'(p_l));
               chk("rid_hold", 32'(rid), 32'(p_id));
               chk("rresp_hold", 32'(rresp), 32'(p_resp));
            end
            if (cur.k) chk("rdata", rdata, cur.d);
            chk("rresp", 32'(rresp), 32'(cur.resp));
            chk("rlast", 32'(rlast), 32'(cur.last));
            chk("rid", 32'(rid), 32'(cur.id));
            p_stall = !rready;
            p_d = rdata; p_l = rlast; p_id = rid; p_resp = rresp;
            if (rready) begin
               last_rd.push_back(rdata);
               last_rresp = rresp;
               last_rid = rid;
               if (rlast) last_rl = last_rd.size();
               void'(rq.pop_front());
               if (cur.last) begin
                  r_act = 0;
                  rd_cnt++;
               end
            end
         end else begin
            p_stall = 0;
         end
         if (bvalid && w_rsp) begin
            chk("bresp", 32'(bresp), 32'(e_bresp));
            chk("bid", 32'(bid), 32'(w_id));
            last_bresp = bresp;
            last_bid = bid;
            if (bready) begin
               w_act = 0; w_rsp = 0; wr_cnt++;
            end
         end
         // AR before W: a read issued alongside a write sees old data
         if (arvalid && arready) begin
            m_idx = int'((araddr >> 2) & (DEPTH - 1));
            m_err = is_err(arsize, arburst);
            last_rd.delete();
            last_rl = 0;
            r_act = 1;
            for (int k = 0; k <= int'(arlen); k++) begin
               cur.d    = m_err ? 32'h0 : mm[m_idx];
               cur.k    = m_err ? 1'b1 : kn[m_idx];
               cur.resp = m_err ? 2'b10 : 2'b00;
               cur.last = (k == int'(arlen));
               cur.id   = arid;
               rq.push_back(cur);
               if (arburst == 2'b01) m_idx = (m_idx + 1) % DEPTH;
            end
         end
         if (awvalid && awready) begin
            w_act  = 1;
            w_idx  = int'((awaddr >> 2) & (DEPTH - 1));
            w_left = int'(awlen) + 1;
            w_incr = (awburst == 2'b01);
            w_err  = is_err(awsize, awburst);
            w_slv  = w_err;
            w_id   = awid;
         end
         if (wvalid && wready && w_act && !w_rsp) begin
            if (!w_err) begin
               for (int b = 0; b < 4; b++)
                  if (wstrb[b]) mm[w_idx][8*b +: 8] = wdata[8*b +: 8];
               if (wstrb == 4'hF) kn[w_idx] = 1;
            end
            if (wlast != (w_left == 1)) w_slv = 1;
            w_left--;
            if (w_incr) w_idx = (w_idx + 1) % DEPTH;
            if (w_left == 0) begin
               w_rsp = 1;
               e_bresp = w_slv ? 2'b10 : 2'b00;
            end
         end
      end
   end

   // ---------------- drivers ----------------
   int rmode = 0;
   int bmode = 0;
   int pcnt  = 0;

   initial begin
      rready = 1'b1;
      bready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            1: rready = 1'($urandom_range(0, 1));
            2: begin
               rready = (pcnt % 3 == 0);
               pcnt++;
            end
            default: rready = 1'b1;
         endcase
         bready = (bmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic rdy(input int ch);
      case (ch)
         0: return awready;
         1: return wready;
         default: return arready;
      endcase
   endfunction

   task automatic wait_rdy(input int ch, input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rdy(ch) && n < LIM);
      if (!rdy(ch)) timeout(nm);
      tick();
   endtask

   task automatic aw_send(input logic id, input logic [31:0] a,
                          input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bu);
      awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu;
      awvalid = 1'b1;
      wait_rdy(0, "aw_wait");
      awvalid = 1'b0;
   endtask

   task automatic w_beat(input logic [31:0] d, input logic [3:0] s,
                         input logic l);
      wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
      wait_rdy(1, "w_wait");
      wvalid = 1'b0;
   endtask

   task automatic ar_send(input logic id, input logic [31:0] a,
                          input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bu);
      arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu;
      arvalid = 1'b1;
      wait_rdy(2, "ar_wait");
      arvalid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((w_act || r_act) && n < LIM);
      if (w_act || r_act) timeout("idle_wait");
      tick();
   endtask

   task automatic wr1(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
      aw_send(1'b0, a, 8'd0, 3'd2, 2'b01);
      w_beat(d, s, 1'b1);
      wait_idle();
   endtask

   task automatic rd(input logic [31:0] a, input logic [7:0] len,
                     input logic [2:0] sz);
      ar_send(1'b0, a, len, sz, 2'b01);
      wait_idle();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_rd;
      int bad;
      int len;
      logic [31:0] la;
      foreach (mm[i]) begin
         mm[i] = 32'h0;
         kn[i] = 0;
      end
      areset = 1'b1;
      awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
      awlock = 0; awcache = 0; awprot = 0; awqos = 0; awvalid = 0;
      wdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
      arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
      arlock = 0; arcache = 0; arprot = 0; arqos = 0; arvalid = 0;
      la = 0;

      @(negedge clk);
      chk("rst_awready", 32'(awready), 1);
      chk("rst_arready", 32'(arready), 1);
      chk("rst_wready", 32'(wready), 0);
      chk("rst_bvalid", 32'(bvalid), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_rlast", 32'(rlast), 0);
      chk("rst_bresp", 32'(bresp), 0);
      chk("rst_rresp", 32'(rresp), 0);
      chk("rst_bid", 32'(bid), 0);
      chk("rst_rid", 32'(rid), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_wr_bursts", 32'(wr_bursts), 0);
      chk("rst_rd_bursts", 32'(rd_bursts), 0);
      tick();
      areset = 1'b0;
      tick();

      // 4-beat INCR write then readback
      aw_send(1'b1, 32'h100, 8'd3, 3'd2, 2'b01);
      for (int i = 0; i < 4; i++) w_beat(32'hA0 + i, 4'hF, i == 3);
      wait_idle();
      chk("t1_bresp", 32'(last_bresp), 0);
      chk("t1_bid", 32'(last_bid), 1);
      ar_send(1'b1, 32'h100, 8'd3, 3'd2, 2'b01);
      wait_idle();
      chk("t1_nbeats", 32'(last_rd.size()), 4);
      for (int i = 0; i < 4; i++) chk("t1_rdata", last_rd[i], 32'hA0 + i);
      chk("t1_rlast_pos", 32'(last_rl), 4);
      chk("t1_rid", 32'(last_rid), 1);

      // byte strobes
      wr1(32'h0, 32'hFFFF_FFFF, 4'hF);
      wr1(32'h0, 32'h1122_3344, 4'b0101);
      rd(32'h0, 8'd0, 3'd2);
      chk("strb_merge", last_rd[0], 32'hFF22_FF44);

      // bad size: beats consumed, nothing written, SLVERR
      wr1(32'h200, 32'h55AA_55AA, 4'hF);
      aw_send(1'b0, 32'h200, 8'd1, 3'd3, 2'b01);
      w_beat(32'hDEAD_0000, 4'hF, 1'b0);
      w_beat(32'hDEAD_0001, 4'hF, 1'b1);
      wait_idle();
      chk("bad_size_bresp", 32'(last_bresp), 2);
      rd(32'h200, 8'd0, 3'd2);
      chk("bad_size_keep", last_rd[0], 32'h55AA_55AA);
      rd(32'h200, 8'd1, 3'd3);
      chk("bad_rd_resp", 32'(last_rresp), 2);
      chk("bad_rd_data", last_rd[1], 0);
      chk("bad_rd_beats", 32'(last_rd.size()), 2);

      // 8-beat read with rready 1,0,0,1,...
      aw_send(1'b0, 32'h400, 8'd7, 3'd2, 2'b01);
      for (int i = 0; i < 8; i++) w_beat(32'h1000 + i, 4'hF, i == 7);
      wait_idle();
      exp_rd = rd_cnt + 1;
      pcnt = 0;
      rmode = 2;
      rd(32'h400, 8'd7, 3'd2);
      rmode = 0;
      chk("stall_nbeats", 32'(last_rd.size()), 8);
      for (int i = 0; i < 8; i++)
         chk("stall_rdata", last_rd[i], 32'h1000 + i);
      chk("stall_rd_bursts", 32'(rd_bursts), 32'(exp_rd));

      // index wrap with early wlast
      aw_send(1'b0, 32'h3FFC, 8'd1, 3'd2, 2'b01);
      w_beat(32'hBEEF_0001, 4'hF, 1'b1);
      w_beat(32'hBEEF_0002, 4'hF, 1'b1);
      wait_idle();
      chk("wrap_bresp", 32'(last_bresp), 2);
      rd(32'h0, 8'd0, 3'd2);
      chk("wrap_idx0", last_rd[0], 32'hBEEF_0002);
      rd(32'h3FFC, 8'd1, 3'd2);
      chk("wrap_rd0", last_rd[0], 32'hBEEF_0001);
      chk("wrap_rd1", last_rd[1], 32'hBEEF_0002);

      // same-cycle write and read of one word
      wr1(32'h800, 32'h0000_5A5A, 4'hF);
      aw_send(1'b0, 32'h800, 8'd0, 3'd2, 2'b01);
      wdata = 32'h1234_5678; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
      arid = 1'b1; araddr = 32'h800; arlen = 0; arsize = 3'd2;
      arburst = 2'b01; arvalid = 1'b1;
      @(negedge clk);
      chk("rf_align", 32'(wready && arready), 1);
      tick();
      wvalid = 1'b0;
      arvalid = 1'b0;
      wait_idle();
      chk("rf_old", last_rd[0], 32'h0000_5A5A);
      rd(32'h800, 8'd0, 3'd2);
      chk("rf_new", last_rd[0], 32'h1234_5678);

      // reset mid-burst
      aw_send(1'b0, 32'h600, 8'd3, 3'd2, 2'b01);
      w_beat(32'h7777_0000, 4'hF, 1'b0);
      w_beat(32'h7777_0001, 4'hF, 1'b0);
      wdata = 32'h7777_0002; wlast = 1'b0; wvalid = 1'b1;
      areset = 1'b1;
      @(negedge clk);
      chk("rst_mid_bvalid", 32'(bvalid), 0);
      chk("rst_mid_wready", 32'(wready), 0);
      tick();
      areset = 1'b0;
      wvalid = 1'b0;
      @(negedge clk);
      chk("rst_mid_awready", 32'(awready), 1);
      chk("rst_mid_bvalid2", 32'(bvalid), 0);
      chk("rst_mid_wr_bursts", 32'(wr_bursts), 0);
      chk("rst_mid_rd_bursts", 32'(rd_bursts), 0);
      tick();
      rd(32'h600, 8'd1, 3'd2);
      chk("rst_keep0", last_rd[0], 32'h7777_0000);
      chk("rst_keep1", last_rd[1], 32'h7777_0001);

      // randomized traffic
      rmode = 1;
      bmode = 1;
      for (int it = 0; it < 200; it++) begin
         len = $urandom_range(0, 7);
         if ($urandom_range(0, 1) == 0) begin
            la = {18'h0, 12'($urandom_range(0, DEPTH - 1)), 2'($urandom)};
            aw_send(1'($urandom), la, 8'(len),
                    ($urandom_range(0, 7) == 0) ? 3'd3 : 3'd2,
                    ($urandom_range(0, 7) == 0) ?
                       2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1)));
            bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
            for (int b = 0; b <= len; b++) begin
               repeat ($urandom_range(0, 2)) tick();
               w_beat($urandom,
                      ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                      (b == len) ^ (b == bad));
            end
         end else begin
            if ($urandom_range(0, 1) == 0)
               la = {18'h0, 12'($urandom_range(0, DEPTH - 1)), 2'b00};
            ar_send(1'($urandom), la, 8'(len),
                    ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2,
                    ($urandom_range(0, 7) == 0) ?
                       2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1)));
         end
         wait_idle();
      end
      rmode = 0;
      bmode = 0;
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
